// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if
// Groups the control-side handshake and the shifter-side datapath signals of
// the shift sequencer into one bundle.
//   start/A/amt/LA/LR   : request from the control unit
//   Y/CO/busy/done      : result and handshake back to the control unit
//   sh_a/sh_la/sh_lr    : operand and mode driven to the external shifter
//   sh_y/sh_co          : combinational result and carry from the shifter
// Modports:
//   master : environment side (control unit plus shifter)
//   slave  : the sequencer itself
interface shift_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [AMT_W-1:0] amt;
    logic             LA;
    logic             LR;
    logic [WIDTH-1:0] sh_a;
    logic             sh_la;
    logic             sh_lr;
    logic [WIDTH-1:0] sh_y;
    logic             sh_co;
    logic [WIDTH-1:0] Y;
    logic             CO;
    logic             busy;
    logic             done;

    modport master (
        output start, A, amt, LA, LR, sh_y, sh_co,
        input  sh_a, sh_la, sh_lr, Y, CO, busy, done
    );

    modport slave (
        input  start, A, amt, LA, LR, sh_y, sh_co,
        output sh_a, sh_la, sh_lr, Y, CO, busy, done
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer
// Performs an N-bit shift by stepping an external single-bit combinational
// shifter once per clock. Operand, amount and mode are latched on an accepted
// start; the accumulator feeds the shifter and takes its result every SHIFT
// cycle. Completion is signalled with a one-cycle done pulse.
// Ports:
//   i_clk    : system clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   io_seq   : shift_sequencer_if.slave (request, result, shifter link)
module shift_sequencer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned AMT_W     = 4,
    parameter int unsigned MAX_SHIFT = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    shift_sequencer_if.slave   io_seq
);

    localparam int unsigned CNT_W = $clog2(MAX_SHIFT + 1);
    localparam logic [AMT_W-1:0] MaxAmt = AMT_W'(MAX_SHIFT);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_co;
    logic             r_la;
    logic             r_lr;
    logic             r_busy;
    logic             r_done;

    logic [AMT_W-1:0] w_amt_sat;
    logic [CNT_W-1:0] w_count_init;

    assign w_amt_sat    = (io_seq.amt > MaxAmt) ? MaxAmt : io_seq.amt;
    assign w_count_init = CNT_W'(w_amt_sat);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_count <= '0;
            r_co    <= 1'b0;
            r_la    <= 1'b0;
            r_lr    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                // DONE behaves like IDLE for acceptance so operations can run
                // back to back without an idle bubble.
                StIdle, StDone: begin
                    if (io_seq.start) begin
                        r_acc   <= io_seq.A;
                        r_count <= w_count_init;
                        r_la    <= io_seq.LA;
                        r_lr    <= io_seq.LR;
                        r_co    <= 1'b0;
                        if (w_count_init != '0) begin
                            r_state <= StShift;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end else begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                StShift: begin
                    // start is deliberately not looked at here
                    r_acc   <= io_seq.sh_y;
                    r_co    <= io_seq.sh_co;
                    r_count <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign io_seq.sh_a  = r_acc;
    assign io_seq.sh_la = r_la;
    assign io_seq.sh_lr = r_lr;
    assign io_seq.Y     = r_acc;
    assign io_seq.CO    = r_co;
    assign io_seq.busy  = r_busy;
    assign io_seq.done  = r_done;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(8), .AMT_W(4)) u_if ();

    shift_sequencer #(
        .WIDTH    (8),
        .AMT_W    (4),
        .MAX_SHIFT(8)
    ) u_dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_seq (u_if.slave)
    );

    // External single-bit shifter
    always_comb begin
        if (u_if.sh_la) begin
            u_if.sh_y  = {u_if.sh_a[7], u_if.sh_a[7:1]};
            u_if.sh_co = u_if.sh_a[0];
        end else if (u_if.sh_lr) begin
            u_if.sh_y  = {1'b0, u_if.sh_a[7:1]};
            u_if.sh_co = u_if.sh_a[0];
        end else begin
            u_if.sh_y  = {u_if.sh_a[6:0], 1'b0};
            u_if.sh_co = u_if.sh_a[7];
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [3:0] amt;
        logic       la;
        logic       lr;
        logic [7:0] exp_y;
        logic       exp_co;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Whole-operation reference: result of shifting a by n in the given mode,
    // returned as {co, y}.
    function automatic logic [8:0] model(input logic [7:0] a, input int n,
                                         input logic la, input logic lr);
        logic [15:0] w;
        logic [7:0]  y;
        logic        co;
        if (n == 0) return {1'b0, a};
        if (la) begin
            y  = 8'($signed(a) >>> n);
            co = a[n-1];
        end else if (lr) begin
            w  = {a, 8'h00} >> n;
            y  = w[15:8];
            co = w[7];
        end else begin
            w  = {8'h00, a} << n;
            y  = w[7:0];
            co = w[8];
        end
        return {co, y};
    endfunction

    task automatic do_op(input string nm, input logic [7:0] a, input logic [3:0] amt,
                         input logic la, input logic lr,
                         input logic [7:0] ey, input logic eco);
        int n, busy_cyc, idx;
        bit got;
        logic [8:0] m;
        n = (amt > 4'd8) ? 8 : int'(amt);
        @(negedge clk);
        u_if.start = 1'b1; u_if.A = a; u_if.amt = amt; u_if.LA = la; u_if.LR = lr;
        @(negedge clk);
        u_if.start = 1'b0; u_if.A = 8'h00;
        busy_cyc = 0; got = 1'b0; idx = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (u_if.busy && u_if.done) check({nm, " busy_done_overlap"}, 1, 0);
            if (u_if.done) begin
                got = 1'b1;
                idx = i;
            end else begin
                if (u_if.busy) begin
                    busy_cyc++;
                    m = model(a, i, la, lr);
                    check({nm, " acc_step"}, {24'd0, u_if.Y}, {24'd0, m[7:0]});
                    if (i == 0) begin
                        check({nm, " sh_la"}, {31'd0, u_if.sh_la}, {31'd0, la});
                        check({nm, " sh_lr"}, {31'd0, u_if.sh_lr}, {31'd0, lr});
                    end
                end
                @(negedge clk);
            end
        end
        check({nm, " done_seen"}, {31'd0, got}, 32'd1);
        check({nm, " latency"}, idx, n);
        check({nm, " busy_cycles"}, busy_cyc, n);
        check({nm, " Y"}, {24'd0, u_if.Y}, {24'd0, ey});
        check({nm, " CO"}, {31'd0, u_if.CO}, {31'd0, eco});
    endtask

    initial begin
        int n_done;
        logic [7:0] ra;
        logic [3:0] ramt;
        logic       rla, rlr;
        logic [8:0] m;

        vecs[0] = '{8'h8D, 4'd3,  1'b0, 1'b1, 8'h11, 1'b1};
        vecs[1] = '{8'h90, 4'd2,  1'b1, 1'b0, 8'hE4, 1'b0};
        vecs[2] = '{8'h5A, 4'd0,  1'b0, 1'b0, 8'h5A, 1'b0};
        vecs[3] = '{8'hFF, 4'd12, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{8'h81, 4'd15, 1'b1, 1'b0, 8'hFF, 1'b1};

        u_if.start = 1'b0; u_if.A = 8'h00; u_if.amt = 4'd0; u_if.LA = 1'b0; u_if.LR = 1'b0;

        // Reset state
        #12;
        check("rst Y", {24'd0, u_if.Y}, 32'd0);
        check("rst CO", {31'd0, u_if.CO}, 32'd0);
        check("rst busy", {31'd0, u_if.busy}, 32'd0);
        check("rst done", {31'd0, u_if.done}, 32'd0);
        check("rst sh_la", {31'd0, u_if.sh_la}, 32'd0);
        check("rst sh_lr", {31'd0, u_if.sh_lr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int v = 0; v < 5; v++) begin
            do_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].amt, vecs[v].la, vecs[v].lr,
                  vecs[v].exp_y, vecs[v].exp_co);
        end

        // Start during SHIFT is ignored, start during DONE is accepted
        @(negedge clk);
        u_if.start = 1'b1; u_if.A = 8'h01; u_if.amt = 4'd4; u_if.LA = 1'b0; u_if.LR = 1'b0;
        @(negedge clk);
        u_if.start = 1'b0;
        @(negedge clk);
        u_if.start = 1'b1; u_if.A = 8'hFF; u_if.amt = 4'd2; u_if.LR = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        check("ign busy", {31'd0, u_if.busy}, 32'd1);
        check("ign acc", {24'd0, u_if.Y}, 32'h04);
        n_done = 2;
        while (!u_if.done && n_done < 30) begin
            @(negedge clk);
            n_done++;
        end
        check("ign latency", n_done, 4);
        check("ign Y", {24'd0, u_if.Y}, 32'h10);
        check("ign CO", {31'd0, u_if.CO}, 32'd0);
        u_if.start = 1'b1; u_if.A = 8'h5A; u_if.amt = 4'd1; u_if.LA = 1'b0; u_if.LR = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        check("b2b busy", {31'd0, u_if.busy}, 32'd1);
        check("b2b acc", {24'd0, u_if.Y}, 32'h5A);
        @(negedge clk);
        check("b2b done", {31'd0, u_if.done}, 32'd1);
        check("b2b Y", {24'd0, u_if.Y}, 32'h2D);
        check("b2b CO", {31'd0, u_if.CO}, 32'd0);

        // Reset mid-operation
        @(negedge clk);
        u_if.start = 1'b1; u_if.A = 8'hC3; u_if.amt = 4'd5; u_if.LA = 1'b0; u_if.LR = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        @(negedge clk);
        check("rmid busy_before", {31'd0, u_if.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rmid Y", {24'd0, u_if.Y}, 32'd0);
        check("rmid CO", {31'd0, u_if.CO}, 32'd0);
        check("rmid busy", {31'd0, u_if.busy}, 32'd0);
        check("rmid done", {31'd0, u_if.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (u_if.done || u_if.busy) n_done++;
        end
        check("rmid no_done_after", n_done, 0);
        do_op("after_rst", 8'hC3, 4'd5, 1'b0, 1'b1, 8'h06, 1'b0);

        // Randomized operations against the reference model
        for (int r = 0; r < 30; r++) begin
            ra   = 8'($urandom);
            ramt = 4'($urandom_range(0, 15));
            rla  = 1'($urandom);
            rlr  = 1'($urandom);
            m    = model(ra, (ramt > 4'd8) ? 8 : int'(ramt), rla, rlr);
            do_op($sformatf("rand%0d", r), ra, ramt, rla, rlr, m[7:0], m[8]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that performs N-bit shifts by iterating the ALU's single-bit shifter once per clock.
- Sits between the control unit and the shifter datapath.
- Latches operand, amount and mode on `start`, drives the shifter each cycle, and returns the final result and carry with a `busy`/`done` handshake.
- The shifter stays combinational and external; this block only sequences it.

Parameters:
- WIDTH, 8, operand/result width; must match the shifter data width.
- AMT_W, 4, width of the shift-amount input.
- MAX_SHIFT, 8, saturation limit for the requested amount; equals WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled on the rising edge.
- A  input  WIDTH  operand, captured on an accepted start.
- amt  input  AMT_W  requested shift count.
- LA  input  1  1 = arithmetic shift right, 0 = logical shift.
- LR  input  1  logical direction: 1 = right, 0 = left; ignored when LA=1.
- sh_a  output  WIDTH  operand to the shifter; always equals the internal accumulator.
- sh_la  output  1  latched LA to the shifter.
- sh_lr  output  1  latched LR to the shifter.
- sh_y  input  WIDTH  shifter result, combinational from sh_a in the same cycle.
- sh_co  input  1  shifter carry-out, i.e. the bit shifted out.
- Y  output  WIDTH  accumulator; this is the final result once done has pulsed.
- CO  output  1  last bit shifted out; 0 if no shift was performed.
- busy  output  1  high while in SHIFT.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Reset: rst_n low forces, asynchronously:
  - state=IDLE, accumulator=0, count=0;
  - Y=0, CO=0, busy=0, done=0, sh_la=0, sh_lr=0.
  - Reset mid-operation aborts it; there is no completion pulse afterwards.
- States: IDLE, SHIFT, DONE.
- Start acceptance:
  - Accepted in IDLE or DONE (back-to-back operations allowed).
  - Ignored in SHIFT, with no effect on the operation in flight.
- On an accepted start:
  - accumulator <= A;
  - count <= min(amt, MAX_SHIFT);
  - latch LA and LR;
  - CO <= 0.
  - Next state: SHIFT if the saturated count is nonzero, else DONE.
- SHIFT, each cycle:
  - accumulator <= sh_y, CO <= sh_co, count <= count-1;
  - when count==1, next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE unless a new start is accepted in that same cycle.
- Latency: start accepted at edge 0, done high in the cycle after edge n, where n = saturated amount. An amount of 0 gives done in the cycle after edge 0.
- Y and CO hold their final values from done until the next accepted start.
- Output meaning by state:
  - busy = (state==SHIFT);
  - done = (state==DONE);
  - busy and done are never high together.
- Amount saturation: amt > MAX_SHIFT is treated as MAX_SHIFT. A logical shift by 8 yields 0; an arithmetic shift by 8 yields all sign bits.
- No arithmetic inside the block beyond the count decrement. Count never underflows because it is only decremented in SHIFT with count ≥ 1.

Test Plan:
- Logical right: start, A=0x8D, amt=3, LA=0, LR=1 -> busy for 3 cycles; done in cycle 4 with Y=0x11, CO=1. Intermediate accumulator values 0x46, 0x23, 0x11.
- Arithmetic right: A=0x90, amt=2, LA=1 -> Y=0xE4, CO=0; done 2 cycles after acceptance. sh_la=1 throughout.
- Zero amount: A=0x5A, amt=0 -> busy never asserts; done in the next cycle with Y=0x5A, CO=0.
- Saturation: A=0xFF, amt=12, LA=0, LR=0 -> exactly 8 SHIFT cycles; Y=0x00, CO=1.
- Start during SHIFT: A=0x01, amt=4, LSL; pulse start with A=0xFF on cycle 2 -> ignored; Y=0x10, CO=0. Start asserted during DONE is accepted immediately.
- Reset mid-op: drop rst_n during cycle 2 of a 5-shift -> Y, CO, busy and done all 0 immediately; no done pulse after release; next start operates normally.
